// File: rtl/regfile_wr_scheduler.sv
// Round-robin write-port scheduler for the physical register file SRAM.
// Define RF_INIT_EN to compile in the post-reset array zeroing (INIT state).
module regfile_wr_scheduler #(
  parameter int unsigned SRAM_DEPTH = 64,
  parameter int unsigned SRAM_INDEX = 6,
  parameter int unsigned SRAM_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 8,
  parameter int unsigned NUM_WR     = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*SRAM_INDEX-1:0]  req_addr_i,
  input  logic [NUM_REQ*SRAM_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_WR-1:0]              we_o,
  output logic [NUM_WR*SRAM_INDEX-1:0]   addr_wr_o,
  output logic [NUM_WR*SRAM_WIDTH-1:0]   data_wr_o,
  output logic                           init_done_o
);
  localparam int unsigned RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PC_W = $clog2(NUM_WR + 1);

  if (SRAM_DEPTH > (1 << SRAM_INDEX)) begin : g_cfg_err
    $error("SRAM_DEPTH does not fit in SRAM_INDEX address bits");
  end

  logic [SRAM_INDEX-1:0] req_addr [NUM_REQ];
  logic [SRAM_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign req_addr[r] = req_addr_i[r*SRAM_INDEX +: SRAM_INDEX];
    assign req_data[r] = req_data_i[r*SRAM_WIDTH +: SRAM_WIDTH];
  end

  logic [RR_W-1:0]       rr_q, rr_d;
  logic [NUM_WR-1:0]     we_q, we_d;
  logic [SRAM_INDEX-1:0] addr_q [NUM_WR];
  logic [SRAM_INDEX-1:0] addr_d [NUM_WR];
  logic [SRAM_WIDTH-1:0] data_q [NUM_WR];
  logic [SRAM_WIDTH-1:0] data_d [NUM_WR];
  logic                  run_c;
  logic [RR_W-1:0]       scan_idx_c;
  logic [PC_W-1:0]       grant_cnt_c;
  logic                  conflict_c;

`ifdef RF_INIT_EN
  localparam int unsigned IP_W = $clog2(SRAM_DEPTH + NUM_WR);

  typedef enum logic {S_INIT, S_RUN} state_e;
  state_e          state_q, state_d;
  logic [IP_W-1:0] init_ptr_q, init_ptr_d;
  logic            last_init_c;

  assign last_init_c = (init_ptr_q + IP_W'(NUM_WR)) >= IP_W'(SRAM_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == S_INIT) begin
      init_ptr_d = init_ptr_q + IP_W'(NUM_WR);
      if (last_init_c) begin
        state_d    = S_RUN;
        init_ptr_d = '0;
      end
    end
  end

  assign run_c       = (state_q == S_RUN) && !reset;
  assign init_done_o = (state_q == S_RUN);
`else
  assign run_c       = !reset;
  assign init_done_o = !reset;
`endif

  // Grant selection: round-robin scan, skipping addresses already claimed this cycle.
  always_comb begin
    req_ready_o = '0;
    we_d        = '0;
    rr_d        = rr_q;
    scan_idx_c  = '0;
    grant_cnt_c = '0;
    conflict_c  = 1'b0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      addr_d[k] = '0;
      data_d[k] = '0;
    end
`ifdef RF_INIT_EN
    if ((state_q == S_INIT) && !reset) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if ((init_ptr_q + IP_W'(k)) < IP_W'(SRAM_DEPTH)) begin
          we_d[k]   = 1'b1;
          addr_d[k] = SRAM_INDEX'(init_ptr_q + IP_W'(k));
        end
      end
    end
`endif
    if (run_c) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        scan_idx_c = RR_W'((32'(rr_q) + i) % NUM_REQ);
        if (req_valid_i[scan_idx_c] && (grant_cnt_c < PC_W'(NUM_WR))) begin
          conflict_c = 1'b0;
          for (int unsigned k = 0; k < NUM_WR; k++) begin
            if ((PC_W'(k) < grant_cnt_c) && (addr_d[k] == req_addr[scan_idx_c])) begin
              conflict_c = 1'b1;
            end
          end
          if (!conflict_c) begin
            req_ready_o[scan_idx_c] = 1'b1;
            for (int unsigned k = 0; k < NUM_WR; k++) begin
              if (PC_W'(k) == grant_cnt_c) begin
                we_d[k]   = 1'b1;
                addr_d[k] = req_addr[scan_idx_c];
                data_d[k] = req_data[scan_idx_c];
              end
            end
            grant_cnt_c = grant_cnt_c + PC_W'(1);
            rr_d = (scan_idx_c == RR_W'(NUM_REQ - 1)) ? '0 : scan_idx_c + RR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
      we_q <= '0;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      rr_q   <= rr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign we_o = we_q;
  for (genvar k = 0; k < NUM_WR; k++) begin : g_ports
    assign addr_wr_o[k*SRAM_INDEX +: SRAM_INDEX] = addr_q[k];
    assign data_wr_o[k*SRAM_WIDTH +: SRAM_WIDTH] = data_q[k];
  end

endmodule
